usb_tx_sequencer: RTL and testbench

//  Transmit-side packet sequencer for the USB host bit pipeline; sits directly upstream of the NRZI encoder.
//  On a start request, emits SYNC, then payload bits pulled from the serializer with bit stuffing, then EOP (SE0 x2, J).

---
 rtl/usb_pkg.sv | 35 +++
 rtl/usb_stuff_ctr.sv | 26 ++
 rtl/usb_tx_sequencer.sv | 176 +++++++++++++++++
 tb/tb_usb_tx_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared sizes, packet types and FSM encodings for the USB TX sequencer
package usb_pkg;

  localparam int SYNC_BITS   = 8;
  localparam int TOK_BITS    = 24;
  localparam int DATA_BITS   = 88;
  localparam int HS_BITS     = 8;
  localparam int STUFF_LIM   = 6;
  localparam int EOP_SE0_CYC = 2;

  typedef enum logic [1:0] {
    PT_NONE   = 2'b00,
    PT_TOKEN  = 2'b01,
    PT_DATA   = 2'b10,
    PT_HSHAKE = 2'b11
  } pkt_type_t;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t ST_IDLE    = 3'd0;
  localparam tx_state_t ST_SYNC    = 3'd1;
  localparam tx_state_t ST_PAYLOAD = 3'd2;
  localparam tx_state_t ST_STUFF   = 3'd3;
  localparam tx_state_t ST_EOP_SE0 = 3'd4;
  localparam tx_state_t ST_EOP_J   = 3'd5;

  function automatic logic [6:0] payload_len_m1(input pkt_type_t t);
    case (t)
      PT_TOKEN: return 7'(TOK_BITS - 1);
      PT_DATA:  return 7'(DATA_BITS - 1);
      default:  return 7'(HS_BITS - 1);
    endcase
  endfunction

endpackage

// File: rtl/usb_stuff_ctr.sv
// rtl/usb_stuff_ctr.sv - run-of-ones counter that requests a stuffed 0
// o_stuff_req flags the bit that completes a run of STUFF_LIM ones.
module usb_stuff_ctr
  import usb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_bit,
  input  logic i_bit_en,
  input  logic i_clr,
  output logic o_stuff_req
);

  logic [2:0] r_ones;

  assign o_stuff_req = i_bit_en & i_bit & (r_ones == 3'(STUFF_LIM - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_ones <= 3'd0;
    end else if (i_bit_en) begin
      r_ones <= i_bit ? r_ones + 3'd1 : 3'd0;
    end
  end

endmodule

// File: rtl/usb_tx_sequencer.sv
// rtl/usb_tx_sequencer.sv - SYNC / stuffed payload / EOP sequencer ahead of the NRZI encoder
// r_state names what the next registered output cycle will carry.
module usb_tx_sequencer
  import usb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pkt_start,
  input  logic [1:0] i_pkt_type,
  output logic       o_pkt_busy,
  input  logic       i_bit_in,
  input  logic       i_bit_valid,
  output logic       o_bit_ready,
  output logic       o_tx_bit,
  output logic [1:0] o_tx_type,
  output logic       o_tx_nrzi_en,
  output logic       o_tx_se0,
  output logic       o_pkt_done,
  output logic       o_pkt_err
);

  tx_state_t r_state, w_state;
  logic [6:0] r_cnt, w_cnt, r_len_m1, w_len_m1;
  pkt_type_t r_type, w_type;
  logic r_last, w_last;
  logic r_tx_bit, w_tx_bit, r_nrzi, w_nrzi, r_se0, w_se0;
  logic r_busy, w_busy, r_done, w_done, r_err, w_err;
  logic [1:0] r_tx_type, w_tx_type;
  logic w_ones_bit, w_ones_en, w_ones_clr, w_stuff_req;

  usb_stuff_ctr u_stuff (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_bit      (w_ones_bit),
    .i_bit_en   (w_ones_en),
    .i_clr      (w_ones_clr),
    .o_stuff_req(w_stuff_req)
  );

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_len_m1   = r_len_m1;
    w_type     = r_type;
    w_last     = r_last;
    w_tx_bit   = 1'b1;
    w_tx_type  = PT_NONE;
    w_nrzi     = 1'b0;
    w_se0      = 1'b0;
    w_busy     = 1'b1;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_ones_bit = 1'b0;
    w_ones_en  = 1'b0;
    w_ones_clr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (i_pkt_start && (i_pkt_type != PT_NONE)) begin
          w_type    = pkt_type_t'(i_pkt_type);
          w_len_m1  = payload_len_m1(pkt_type_t'(i_pkt_type));
          w_cnt     = 7'd1;
          w_last    = 1'b0;
          w_state   = ST_SYNC;
          w_tx_bit  = 1'b0;
          w_tx_type = i_pkt_type;
          w_nrzi    = 1'b1;
          w_busy    = 1'b1;
          w_ones_en = 1'b1;
        end
      end
      ST_SYNC: begin
        w_tx_bit   = (r_cnt == 7'(SYNC_BITS - 1));
        w_tx_type  = r_type;
        w_nrzi     = 1'b1;
        w_ones_en  = 1'b1;
        w_ones_bit = w_tx_bit;
        if (r_cnt == 7'(SYNC_BITS - 1)) begin
          w_cnt   = 7'd0;
          w_state = ST_PAYLOAD;
        end else begin
          w_cnt = r_cnt + 7'd1;
        end
      end
      ST_PAYLOAD: begin
        if (i_bit_valid) begin
          w_tx_bit   = i_bit_in;
          w_tx_type  = r_type;
          w_nrzi     = 1'b1;
          w_ones_en  = 1'b1;
          w_ones_bit = i_bit_in;
          if (r_cnt == r_len_m1) begin
            w_last  = 1'b1;
            w_cnt   = 7'd0;
            w_state = w_stuff_req ? ST_STUFF : ST_EOP_SE0;
          end else begin
            w_cnt   = r_cnt + 7'd1;
            w_state = w_stuff_req ? ST_STUFF : ST_PAYLOAD;
          end
        end else begin
          // Underrun: the first SE0 goes out right away, so one fewer remains.
          w_tx_bit = 1'b0;
          w_se0    = 1'b1;
          w_err    = 1'b1;
          w_cnt    = 7'd1;
          w_state  = ST_EOP_SE0;
        end
      end
      ST_STUFF: begin
        w_tx_bit   = 1'b0;
        w_tx_type  = r_type;
        w_nrzi     = 1'b1;
        w_ones_clr = 1'b1;
        w_state    = r_last ? ST_EOP_SE0 : ST_PAYLOAD;
      end
      ST_EOP_SE0: begin
        w_tx_bit = 1'b0;
        w_se0    = 1'b1;
        if (r_cnt == 7'(EOP_SE0_CYC - 1)) begin
          w_cnt   = 7'd0;
          w_state = ST_EOP_J;
        end else begin
          w_cnt = r_cnt + 7'd1;
        end
      end
      ST_EOP_J: begin
        w_done  = 1'b1;
        w_state = ST_IDLE;
      end
      default: begin
        w_busy  = 1'b0;
        w_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 7'd0;
      r_len_m1  <= 7'd0;
      r_type    <= PT_NONE;
      r_last    <= 1'b0;
      r_tx_bit  <= 1'b1;
      r_tx_type <= 2'b00;
      r_nrzi    <= 1'b0;
      r_se0     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_len_m1  <= w_len_m1;
      r_type    <= w_type;
      r_last    <= w_last;
      r_tx_bit  <= w_tx_bit;
      r_tx_type <= w_tx_type;
      r_nrzi    <= w_nrzi;
      r_se0     <= w_se0;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_err     <= w_err;
    end
  end

  assign o_bit_ready  = (r_state == ST_PAYLOAD);
  assign o_tx_bit     = r_tx_bit;
  assign o_tx_type    = r_tx_type;
  assign o_tx_nrzi_en = r_nrzi;
  assign o_tx_se0     = r_se0;
  assign o_pkt_busy   = r_busy;
  assign o_pkt_done   = r_done;
  assign o_pkt_err    = r_err;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// tb/tb_usb_tx_sequencer.sv - directed vector bench for usb_tx_sequencer
module tb_usb_tx_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, pkt_start, bit_in, bit_valid;
  logic [1:0] pkt_type;
  logic pkt_busy, bit_ready, tx_bit, tx_nrzi_en, tx_se0, pkt_done, pkt_err;
  logic [1:0] tx_type;

  usb_tx_sequencer dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pkt_start (pkt_start),
    .i_pkt_type  (pkt_type),
    .o_pkt_busy  (pkt_busy),
    .i_bit_in    (bit_in),
    .i_bit_valid (bit_valid),
    .o_bit_ready (bit_ready),
    .o_tx_bit    (tx_bit),
    .o_tx_type   (tx_type),
    .o_tx_nrzi_en(tx_nrzi_en),
    .o_tx_se0    (tx_se0),
    .o_pkt_done  (pkt_done),
    .o_pkt_err   (pkt_err)
  );

  // Output word: {tx_bit, tx_type[1:0], nrzi_en, se0, busy, done, err, bit_ready}
  typedef struct {
    logic       start;
    logic [1:0] ptype;
    logic       valid;
    logic       bit_v;
    logic [8:0] exp;
  } vec_t;

  localparam logic [8:0] IDLE_O = 9'b1_00_0_0_0_0_0_0;

  vec_t ack_tab[20];
  logic [7:0] ack_bits;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {tx_bit, tx_type, tx_nrzi_en, tx_se0, pkt_busy, pkt_done, pkt_err, bit_ready};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [1:0] t, input logic v, input logic b);
    pkt_start = s;
    pkt_type  = t;
    bit_valid = v;
    bit_in    = b;
  endtask

  task automatic run_ack(input string tag);
    for (int c = 0; c < 20; c++) begin
      if (c > 0) step();
      chk($sformatf("%s[%0d]", tag, c), 64'(outs()), 64'(ack_tab[c].exp));
      drive(ack_tab[c].start, ack_tab[c].ptype, ack_tab[c].valid, ack_tab[c].bit_v);
    end
  endtask

  initial begin
    int done_cyc, ready_cnt, err_cnt, got_n, stuff_rdy;
    logic [63:0] got_v, exp_v, low_mask;
    int stuff_exp[36];
    int done_q[$];

    ack_bits = 8'b1101_0010;
    for (int c = 0; c < 20; c++) begin
      ack_tab[c].start = (c == 0);
      ack_tab[c].ptype = 2'b11;
      ack_tab[c].valid = (c >= 8 && c <= 15);
      ack_tab[c].bit_v = (c >= 8 && c <= 15) ? ack_bits[c-8] : 1'b0;
      if (c == 0)       ack_tab[c].exp = IDLE_O;
      else if (c <= 7)  ack_tab[c].exp = 9'b0_11_1_0_1_0_0_0;
      else if (c == 8)  ack_tab[c].exp = 9'b1_11_1_0_1_0_0_1;
      else if (c <= 16) ack_tab[c].exp = {ack_bits[c-9], 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, (c <= 15)};
      else if (c <= 18) ack_tab[c].exp = 9'b0_00_0_1_1_0_0_0;
      else              ack_tab[c].exp = 9'b1_00_0_0_1_1_0_0;
    end

    rst = 1'b1;
    drive(0, 2'b00, 0, 0);
    repeat (3) step();
    chk("reset_hold", 64'(outs()), 64'(IDLE_O));
    rst = 1'b0;
    step();
    chk("reset_idle", 64'(outs()), 64'(IDLE_O));

    run_ack("ack");
    step();
    chk("ack_after", 64'(outs()), 64'(IDLE_O));

    drive(1, 2'b00, 0, 0);
    step();
    chk("type00_ignored", 64'(outs()), 64'(IDLE_O));
    drive(0, 2'b00, 0, 0);
    step();
    chk("type00_still_idle", 64'(outs()), 64'(IDLE_O));

    // Starts during a handshake packet are dropped.
    done_cyc = -1;
    drive(1, 2'b11, 0, 0);
    for (int c = 1; c <= 22; c++) begin
      step();
      if (pkt_done && done_cyc < 0) done_cyc = c;
      if (c == 6 || c == 13) chk($sformatf("busy_type[%0d]", c), 64'(tx_type), 64'(2'b11));
      if (c == 20) chk("busy_ign_idle", 64'(outs()), 64'(IDLE_O));
      drive(c == 5 || c == 12, (c == 5 || c == 12) ? 2'b10 : 2'b00,
            c >= 8 && c <= 15, (c >= 8 && c <= 15) ? ack_bits[(c-8)%8] : 1'b0);
    end
    chk("busy_ign_done_cyc", 64'(done_cyc), 64'(19));

    // Token of all ones: stuffing after payload bits 5, 11, 17, 23.
    stuff_exp = '{0,0,0,0,0,0,0,1, 1,1,1,1,1,0, 1,1,1,1,1,1,0, 1,1,1,1,1,1,0,
                  1,1,1,1,1,1,0, 1};
    exp_v = '0;
    for (int i = 0; i < 36; i++) exp_v[i] = stuff_exp[i][0];
    got_v = '0; got_n = 0; ready_cnt = 0; stuff_rdy = 0; done_cyc = -1;
    drive(1, 2'b01, 1, 1);
    for (int c = 1; c <= 45; c++) begin
      step();
      if (tx_nrzi_en) begin
        if (got_n < 64) got_v[got_n] = tx_bit;
        got_n++;
      end
      if (bit_ready) ready_cnt++;
      if ((c == 13 || c == 20 || c == 27 || c == 34) && bit_ready) stuff_rdy++;
      if (pkt_done && done_cyc < 0) done_cyc = c;
      drive(0, 2'b00, c < 45, c < 45);
    end
    chk("stuff_nrzi_cycles", 64'(got_n), 64'(36));
    chk("stuff_stream", got_v, exp_v);
    chk("stuff_bits_pulled", 64'(ready_cnt), 64'(24));
    chk("stuff_ready_low", 64'(stuff_rdy), 64'(0));
    chk("stuff_done_cyc", 64'(done_cyc), 64'(39));

    // Data packet starves after 10 payload bits.
    ready_cnt = 0; err_cnt = 0;
    drive(1, 2'b10, 0, 0);
    for (int c = 1; c <= 25; c++) begin
      step();
      if (pkt_err) err_cnt++;
      if (c >= 19 && bit_ready) ready_cnt++;
      if (c == 18) chk("ur_ready18", 64'(bit_ready), 64'(1));
      if (c == 19) chk("ur_first_se0", 64'({tx_se0, pkt_err, tx_type, tx_nrzi_en}), 64'(5'b11_00_0));
      if (c == 20) chk("ur_second_se0", 64'({tx_se0, pkt_err, tx_bit}), 64'(3'b100));
      if (c == 21) chk("ur_j_done", 64'({tx_bit, pkt_done, tx_se0}), 64'(3'b110));
      if (c == 22) chk("ur_idle", 64'(outs()), 64'(IDLE_O));
      drive(0, 2'b00, c >= 8 && c <= 17, c[0]);
    end
    chk("ur_no_ready_after", 64'(ready_cnt), 64'(0));
    chk("ur_err_pulses", 64'(err_cnt), 64'(1));

    // Reset during payload bit 4, then a fresh handshake.
    drive(1, 2'b10, 0, 0);
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 13) chk("abort_outputs", 64'(outs()), 64'(IDLE_O));
      rst = (c == 12);
      drive(0, 2'b00, c >= 8, 1'b1);
    end
    drive(0, 2'b00, 0, 0);
    step();
    run_ack("ack2");

    // Start held high: second packet begins right after the first J.
    low_mask = '0;
    drive(1, 2'b11, 1, 0);
    for (int c = 1; c <= 40; c++) begin
      step();
      if (pkt_done) done_q.push_back(c);
      if (c <= 38 && !tx_nrzi_en) low_mask[c] = 1'b1;
      if (c == 20) chk("b2b_second_sync", 64'({tx_bit, tx_type, tx_nrzi_en}), 64'(4'b0_11_1));
      if (c == 40) chk("b2b_idle", 64'(outs()), 64'(IDLE_O));
      drive(c < 37, 2'b11, c < 37, 0);
    end
    chk("b2b_done_count", 64'(done_q.size()), 64'(2));
    if (done_q.size() == 2) begin
      chk("b2b_done0", 64'(done_q[0]), 64'(19));
      chk("b2b_done1", 64'(done_q[1]), 64'(38));
    end
    chk("b2b_nrzi_low_mask", low_mask,
        64'((64'd1 << 17) | (64'd1 << 18) | (64'd1 << 19) | (64'd1 << 36) | (64'd1 << 37) | (64'd1 << 38)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
